dbg_mem_arbiter: RTL and testbench
==================================

Name: dbg_mem_arbiter

Overview:
- Shares the single data-memory port between the core load/store unit and the debug module memory interface (mem_we/mem_addr/mem_wdata/op_req).
- Sits between the core, the debug module and the data RAM.
- Grants one access per cycle, then routes the read data back to the requester that issued the read.
- Debug has priority over the core. A starvation counter guarantees the core forward progress while the core is not halted.

Parameters:
- AW, 32, address width
- DW, 32, data width
- STARVE_LIMIT, 8, consecutive denied core-request cycles before the core is force-granted (range 1..255)

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  reset, asynchronous, active-high
- halted_i  in  1  core halted by debug; disables the starvation override
- core_req_i  in  1  core access request (level; held until granted)
- core_we_i  in  1  core write enable
- core_addr_i  in  AW  core address
- core_wdata_i  in  DW  core write data
- core_gnt_o  out  1  core request accepted this cycle
- core_rvalid_o  out  1  core read data valid
- core_rdata_o  out  DW  core read data
- dbg_req_i  in  1  debug access request (level; held until granted)
- dbg_we_i  in  1  debug write enable
- dbg_addr_i  in  AW  debug address
- dbg_wdata_i  in  DW  debug write data
- dbg_gnt_o  out  1  debug request accepted this cycle
- dbg_rvalid_o  out  1  debug read data valid
- dbg_rdata_o  out  DW  debug read data
- mem_req_o  out  1  memory access strobe
- mem_we_o  out  1  memory write enable
- mem_addr_o  out  AW  memory address
- mem_wdata_o  out  DW  memory write data
- mem_rdata_i  in  DW  memory read data, valid exactly 1 cycle after an accepted read
- starve_o  out  1  core force-grant active this cycle (observability)

Behaviour:
Grant selection (combinational, same cycle)
- Force-grant condition: force = core_req_i && !halted_i && (starve_cnt == STARVE_LIMIT).
- If force: the core is granted.
- Else if dbg_req_i: debug is granted.
- Else if core_req_i: the core is granted.
- Else: no grant.
- At most one grant per cycle; core_gnt_o and dbg_gnt_o are never high together.

Memory port
- mem_req_o = core_gnt_o | dbg_gnt_o.
- mem_we_o, mem_addr_o and mem_wdata_o are muxed from the granted requester.
- With no grant these outputs are 0.
- Writes complete in the grant cycle and produce no rvalid.

Starvation counter
- 8-bit, reset 0.
- Increments (saturating at STARVE_LIMIT) each cycle core_req_i && !core_gnt_o && !halted_i.
- Clears on core_gnt_o or when core_req_i is low.
- Holds its value while halted_i is high.
- starve_o = force.

Response path
- Registered owner state, reset RESP_NONE; states RESP_NONE, RESP_CORE, RESP_DBG.
- Next state is RESP_CORE if the core was granted with we=0, RESP_DBG if debug was granted with we=0, else RESP_NONE.
- core_rvalid_o = (state == RESP_CORE); dbg_rvalid_o = (state == RESP_DBG).
- Read latency is 1 cycle: grant in cycle N gives rvalid in N+1.
- Back-to-back reads are fully pipelined, one per cycle, owners may alternate.
- core_rdata_o and dbg_rdata_o equal mem_rdata_i when the matching rvalid is high, else 0.

Reset
- All registered state clears immediately.
- Every output is 0 while rst_i is high. This holds because grants are gated by !rst_i, which is asserted asynchronously.
- A read granted in the cycle before reset asserts produces no rvalid after reset; the response is dropped.

Simultaneous events
- Requests from both sides: debug wins unless force is true.
- A core request is dropped mid-wait: the counter clears and no grant is issued.
- halted_i rises while force is true: force drops the same cycle and debug wins.

Decomposition:
- Shared package dbg_arb_pkg holds:
  - enum resp_owner_e {RESP_NONE, RESP_CORE, RESP_DBG}
  - struct mem_req_t {we, addr, wdata}, used for both requester inputs and the memory output mux
  - the counter width constant STARVE_CW = 8
- No sub-module. Grant logic, counter and response register live in one module of roughly 150 lines.

Test Plan:
- Debug read alone: dbg_req=1, addr=0x100, mem returns 0xDEADBEEF -> dbg_gnt in the same cycle, dbg_rvalid=1 with dbg_rdata=0xDEADBEEF one cycle later; no core signals toggle.
- Conflict: both request continuously, STARVE_LIMIT=8, halted_i=0 -> 8 debug grants, then 1 core grant with starve_o=1, then the pattern repeats every 9 cycles.
- Same conflict with halted_i=1 -> debug granted every cycle, the core is never granted, the counter holds.
- Alternating reads: core read 0x0, debug read 0x4 on consecutive cycles -> rvalids on consecutive cycles to the correct owners, data not swapped.
- Write: core_we=1, addr=0x20, wdata=0x12345678 -> mem_req=1, mem_we=1, mem_wdata=0x12345678 in the grant cycle; no rvalid follows.
- Reset mid-read: grant a debug read, assert rst_i the next cycle -> all outputs 0, no dbg_rvalid, counter 0 after release.

Source files
------------

// File: rtl/dbg_arb_pkg.sv
// dbg_arb_pkg
// Shared types and constants for the debug/core data-memory arbiter.
//   resp_owner_e : who owns the read response arriving next cycle
//   mem_req_t    : one memory access (write enable, address, write data)
//   STARVE_CW    : width of the core starvation counter
//   MEM_AW/MEM_DW: widths of the access struct; the arbiter's AW/DW
//                  parameters must not exceed these
package dbg_arb_pkg;

    localparam int STARVE_CW = 8;
    localparam int MEM_AW    = 32;
    localparam int MEM_DW    = 32;

    typedef enum logic [1:0] {
        RESP_NONE = 2'd0,
        RESP_CORE = 2'd1,
        RESP_DBG  = 2'd2
    } resp_owner_e;

    typedef struct packed {
        logic              we;
        logic [MEM_AW-1:0] addr;
        logic [MEM_DW-1:0] wdata;
    } mem_req_t;

    // Only reads produce a response, so a granted write leaves the
    // response slot empty.
    function automatic resp_owner_e next_owner(input logic core_gnt,
                                               input logic core_we,
                                               input logic dbg_gnt,
                                               input logic dbg_we);
        resp_owner_e owner;
        owner = RESP_NONE;
        if (core_gnt && !core_we) begin
            owner = RESP_CORE;
        end else if (dbg_gnt && !dbg_we) begin
            owner = RESP_DBG;
        end
        return owner;
    endfunction

endpackage

// File: rtl/dbg_mem_arbiter.sv
// dbg_mem_arbiter
// Shares the single data-memory port between the core load/store unit and
// the debug module. Debug has priority; a starvation counter force-grants
// the core after STARVE_LIMIT consecutive denied cycles (1..255) unless the
// core is halted. Read data returns one cycle after the grant and is routed
// to whichever requester issued the read.
// Ports:
//   clk_i, rst_i                  clock, async active-high reset
//   halted_i                      core halted; disables the force-grant
//   core_req/we/addr/wdata_i      core access request
//   core_gnt_o/rvalid_o/rdata_o   core grant and read response
//   dbg_req/we/addr/wdata_i       debug access request
//   dbg_gnt_o/rvalid_o/rdata_o    debug grant and read response
//   mem_req/we/addr/wdata_o       memory port, muxed from the winner
//   mem_rdata_i                   memory read data, 1 cycle after grant
//   starve_o                      core force-grant active this cycle
module dbg_mem_arbiter
    import dbg_arb_pkg::*;
#(
    parameter int AW           = MEM_AW,
    parameter int DW           = MEM_DW,
    parameter int STARVE_LIMIT = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          halted_i,
    input  logic          core_req_i,
    input  logic          core_we_i,
    input  logic [AW-1:0] core_addr_i,
    input  logic [DW-1:0] core_wdata_i,
    output logic          core_gnt_o,
    output logic          core_rvalid_o,
    output logic [DW-1:0] core_rdata_o,
    input  logic          dbg_req_i,
    input  logic          dbg_we_i,
    input  logic [AW-1:0] dbg_addr_i,
    input  logic [DW-1:0] dbg_wdata_i,
    output logic          dbg_gnt_o,
    output logic          dbg_rvalid_o,
    output logic [DW-1:0] dbg_rdata_o,
    output logic          mem_req_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic [DW-1:0] mem_rdata_i,
    output logic          starve_o
);

    localparam logic [STARVE_CW-1:0] LIMIT = STARVE_CW'(STARVE_LIMIT);

    mem_req_t               core_acc;
    mem_req_t               dbg_acc;
    mem_req_t               mem_sel;
    logic                   force_grant;
    logic                   core_gnt;
    logic                   dbg_gnt;
    logic [STARVE_CW-1:0]   starve_cnt_q;
    logic [STARVE_CW-1:0]   starve_cnt_d;
    resp_owner_e            resp_q;
    resp_owner_e            resp_d;

    assign core_acc = '{we: core_we_i, addr: MEM_AW'(core_addr_i), wdata: MEM_DW'(core_wdata_i)};
    assign dbg_acc  = '{we: dbg_we_i,  addr: MEM_AW'(dbg_addr_i),  wdata: MEM_DW'(dbg_wdata_i)};

    // Grant selection. Everything is gated by reset so that all outputs
    // drop to 0 the moment rst_i rises, without waiting for a clock edge.
    always_comb begin
        force_grant = !rst_i && core_req_i && !halted_i && (starve_cnt_q == LIMIT);
        core_gnt    = 1'b0;
        dbg_gnt     = 1'b0;
        if (!rst_i) begin
            if (force_grant) begin
                core_gnt = 1'b1;
            end else if (dbg_req_i) begin
                dbg_gnt = 1'b1;
            end else if (core_req_i) begin
                core_gnt = 1'b1;
            end
        end
    end

    // Memory port mux; idle port drives all zeros.
    always_comb begin
        mem_sel = '0;
        if (core_gnt) begin
            mem_sel = core_acc;
        end else if (dbg_gnt) begin
            mem_sel = dbg_acc;
        end
    end

    // Starvation counter and response owner next-state. The counter
    // freezes while halted so that a resumed core keeps its earned credit.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!halted_i) begin
            if (core_req_i && !core_gnt) begin
                if (starve_cnt_q < LIMIT) begin
                    starve_cnt_d = starve_cnt_q + STARVE_CW'(1);
                end
            end else begin
                starve_cnt_d = '0;
            end
        end
        resp_d = next_owner(core_gnt, core_we_i, dbg_gnt, dbg_we_i);
    end

    // Reset drops any in-flight read response.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            starve_cnt_q <= '0;
            resp_q       <= RESP_NONE;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            resp_q       <= resp_d;
        end
    end

    assign core_gnt_o    = core_gnt;
    assign dbg_gnt_o     = dbg_gnt;
    assign starve_o      = force_grant;
    assign mem_req_o     = core_gnt | dbg_gnt;
    assign mem_we_o      = mem_sel.we;
    assign mem_addr_o    = mem_sel.addr[AW-1:0];
    assign mem_wdata_o   = mem_sel.wdata[DW-1:0];
    assign core_rvalid_o = (resp_q == RESP_CORE);
    assign dbg_rvalid_o  = (resp_q == RESP_DBG);
    assign core_rdata_o  = core_rvalid_o ? mem_rdata_i : '0;
    assign dbg_rdata_o   = dbg_rvalid_o  ? mem_rdata_i : '0;

endmodule

// File: tb/tb_dbg_mem_arbiter.sv
// tb_dbg_mem_arbiter
// Self-checking bench for dbg_mem_arbiter. A behavioural memory answers
// reads one cycle after the access; a reference model tracks how long the
// core has been kept waiting and which read response is due next cycle.
module tb_dbg_mem_arbiter;

    localparam int LIMIT = 8;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        halted_i, core_req_i, core_we_i, dbg_req_i, dbg_we_i;
    logic [31:0] core_addr_i, core_wdata_i, dbg_addr_i, dbg_wdata_i;
    logic        core_gnt_o, core_rvalid_o, dbg_gnt_o, dbg_rvalid_o;
    logic [31:0] core_rdata_o, dbg_rdata_o;
    logic        mem_req_o, mem_we_o, starve_o;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

    typedef struct packed {
        logic        core_gnt;
        logic        core_rvalid;
        logic [31:0] core_rdata;
        logic        dbg_gnt;
        logic        dbg_rvalid;
        logic [31:0] dbg_rdata;
        logic        mem_req;
        logic        mem_we;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic        starve;
    } out_t;

    int          total = 0;
    int          bad   = 0;
    int          streak;
    int          pend_owner;
    logic [31:0] pend_data;
    logic [31:0] exp_ram [256];
    logic [31:0] ram [256];
    out_t        exp_o, obs_o;
    logic        exp_force, exp_cg, exp_dg;

    dbg_mem_arbiter #(.AW(32), .DW(32), .STARVE_LIMIT(LIMIT)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .halted_i(halted_i),
        .core_req_i(core_req_i), .core_we_i(core_we_i),
        .core_addr_i(core_addr_i), .core_wdata_i(core_wdata_i),
        .core_gnt_o(core_gnt_o), .core_rvalid_o(core_rvalid_o),
        .core_rdata_o(core_rdata_o),
        .dbg_req_i(dbg_req_i), .dbg_we_i(dbg_we_i),
        .dbg_addr_i(dbg_addr_i), .dbg_wdata_i(dbg_wdata_i),
        .dbg_gnt_o(dbg_gnt_o), .dbg_rvalid_o(dbg_rvalid_o),
        .dbg_rdata_o(dbg_rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i), .starve_o(starve_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] init_word(input int i);
        return 32'h5A5A_0000 + 32'(i) * 32'h0000_0101;
    endfunction

    function automatic logic [31:0] rand_addr();
        return {22'h0, 8'($urandom_range(0, 255)), 2'b00};
    endfunction

    // Memory: reset loads a known pattern, reads answer next cycle, and
    // idle cycles put junk on the read bus so ungated read data shows up.
    always @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < 256; i++) ram[i] <= init_word(i);
            mem_rdata_i <= $urandom;
        end else if (mem_req_o && mem_we_o) begin
            ram[mem_addr_o[9:2]] <= mem_wdata_o;
            mem_rdata_i <= $urandom;
        end else if (mem_req_o) begin
            mem_rdata_i <= ram[mem_addr_o[9:2]];
        end else begin
            mem_rdata_i <= $urandom;
        end
    end

    function automatic out_t observe();
        out_t o;
        o.core_gnt    = core_gnt_o;
        o.core_rvalid = core_rvalid_o;
        o.core_rdata  = core_rdata_o;
        o.dbg_gnt     = dbg_gnt_o;
        o.dbg_rvalid  = dbg_rvalid_o;
        o.dbg_rdata   = dbg_rdata_o;
        o.mem_req     = mem_req_o;
        o.mem_we      = mem_we_o;
        o.mem_addr    = mem_addr_o;
        o.mem_wdata   = mem_wdata_o;
        o.starve      = starve_o;
        return o;
    endfunction

    // Expected outputs for the current inputs: debug first, unless the
    // core has waited LIMIT cycles and is not halted.
    task automatic model_eval();
        exp_o  = '0;
        exp_cg = 1'b0;
        exp_dg = 1'b0;
        exp_force = 1'b0;
        if (rst_i) begin
            streak     = 0;
            pend_owner = 0;
        end else begin
            exp_force = core_req_i && !halted_i && (streak == LIMIT);
            exp_dg    = dbg_req_i && !exp_force;
            exp_cg    = core_req_i && !exp_dg;
            exp_o.core_gnt = exp_cg;
            exp_o.dbg_gnt  = exp_dg;
            exp_o.mem_req  = exp_cg || exp_dg;
            exp_o.starve   = exp_force;
            if (exp_cg) begin
                exp_o.mem_we    = core_we_i;
                exp_o.mem_addr  = core_addr_i;
                exp_o.mem_wdata = core_wdata_i;
            end else if (exp_dg) begin
                exp_o.mem_we    = dbg_we_i;
                exp_o.mem_addr  = dbg_addr_i;
                exp_o.mem_wdata = dbg_wdata_i;
            end
            if (pend_owner == 1) begin
                exp_o.core_rvalid = 1'b1;
                exp_o.core_rdata  = pend_data;
            end else if (pend_owner == 2) begin
                exp_o.dbg_rvalid = 1'b1;
                exp_o.dbg_rdata  = pend_data;
            end
        end
    endtask

    // Advance the model across one clock edge.
    task automatic model_commit();
        int idx;
        if (rst_i) begin
            streak     = 0;
            pend_owner = 0;
            for (int i = 0; i < 256; i++) exp_ram[i] = init_word(i);
            return;
        end
        if (!halted_i) begin
            if (core_req_i && !exp_cg) streak = (streak < LIMIT) ? streak + 1 : LIMIT;
            else streak = 0;
        end
        pend_owner = 0;
        if (exp_cg) begin
            idx = int'(core_addr_i[9:2]);
            if (core_we_i) exp_ram[idx] = core_wdata_i;
            else begin pend_owner = 1; pend_data = exp_ram[idx]; end
        end else if (exp_dg) begin
            idx = int'(dbg_addr_i[9:2]);
            if (dbg_we_i) exp_ram[idx] = dbg_wdata_i;
            else begin pend_owner = 2; pend_data = exp_ram[idx]; end
        end
    endtask

    task automatic drive(input logic cr, input logic cw, input logic [31:0] ca,
                         input logic [31:0] cd, input logic dr, input logic dw,
                         input logic [31:0] da, input logic [31:0] dd, input logic h);
        core_req_i = cr; core_we_i = cw; core_addr_i = ca; core_wdata_i = cd;
        dbg_req_i  = dr; dbg_we_i  = dw; dbg_addr_i  = da; dbg_wdata_i  = dd;
        halted_i   = h;
    endtask

    task automatic settle();
        #1;
        model_eval();
        obs_o = observe();
    endtask

    task automatic tick();
        @(posedge clk_i);
        model_commit();
        @(negedge clk_i);
    endtask

    task automatic test_reset();
        streak = 0;
        pend_owner = 0;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b0, rand_addr(), $urandom, 1'b1, 1'b0, rand_addr(), $urandom, 1'b0);
            settle();
            total++;
            if (obs_o !== out_t'(0)) begin
                bad++;
                $display("[TB] FAIL reset_outputs: got %h want 0", obs_o);
            end
            tick();
        end
        rst_i = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        settle();
        total++;
        if (obs_o !== exp_o || obs_o !== out_t'(0)) begin
            bad++;
            $display("[TB] FAIL reset_release_idle: got %h want %h", obs_o, exp_o);
        end
        tick();
    endtask

    task automatic test_dbg_read();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 1'b0);
        settle();
        total++;
        if (obs_o !== exp_o) begin
            bad++;
            $display("[TB] FAIL dbg_write_setup: got %h want %h", obs_o, exp_o);
        end
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h100, 32'h0, 1'b0);
        settle();
        total++;
        if ({dbg_gnt_o, core_gnt_o, mem_req_o, mem_we_o, mem_addr_o} !== {4'b1010, 32'h100}) begin
            bad++;
            $display("[TB] FAIL dbg_read_grant: got gnt=%b/%b req=%b we=%b addr=%h want 1/0 1 0 100",
                     dbg_gnt_o, core_gnt_o, mem_req_o, mem_we_o, mem_addr_o);
        end
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        settle();
        total++;
        if ({dbg_rvalid_o, dbg_rdata_o, core_rvalid_o, core_rdata_o, core_gnt_o} !== {1'b1, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0}) begin
            bad++;
            $display("[TB] FAIL dbg_read_data: got rvalid=%b rdata=%h core_rvalid=%b want 1 deadbeef 0",
                     dbg_rvalid_o, dbg_rdata_o, core_rvalid_o);
        end
        total++;
        if (obs_o !== exp_o) begin
            bad++;
            $display("[TB] FAIL dbg_read_model: got %h want %h", obs_o, exp_o);
        end
        tick();
    endtask

    task automatic test_write();
        drive(1'b1, 1'b1, 32'h20, 32'h12345678, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        settle();
        total++;
        if ({core_gnt_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o} !== {3'b111, 32'h20, 32'h12345678}) begin
            bad++;
            $display("[TB] FAIL write_port: got gnt=%b req=%b we=%b addr=%h wdata=%h want 1 1 1 20 12345678",
                     core_gnt_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o);
        end
        tick();
        drive(1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        settle();
        total++;
        if ({core_rvalid_o, dbg_rvalid_o} !== 2'b00) begin
            bad++;
            $display("[TB] FAIL write_no_rvalid: got %b%b want 00", core_rvalid_o, dbg_rvalid_o);
        end
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        settle();
        total++;
        if ({core_rvalid_o, core_rdata_o} !== {1'b1, 32'h12345678}) begin
            bad++;
            $display("[TB] FAIL write_readback: got rvalid=%b rdata=%h want 1 12345678", core_rvalid_o, core_rdata_o);
        end
        tick();
    endtask

    task automatic test_alternating();
        logic [31:0] w0, w1;
        w0 = exp_ram[0];
        w1 = exp_ram[1];
        drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        settle();
        total++;
        if (obs_o !== exp_o) begin
            bad++;
            $display("[TB] FAIL alt_core_grant: got %h want %h", obs_o, exp_o);
        end
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h4, 32'h0, 1'b0);
        settle();
        total++;
        if ({core_rvalid_o, core_rdata_o, dbg_rvalid_o, dbg_gnt_o} !== {1'b1, w0, 1'b0, 1'b1}) begin
            bad++;
            $display("[TB] FAIL alt_core_data: got rvalid=%b rdata=%h dbg_rvalid=%b dbg_gnt=%b want 1 %h 0 1",
                     core_rvalid_o, core_rdata_o, dbg_rvalid_o, dbg_gnt_o, w0);
        end
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        settle();
        total++;
        if ({dbg_rvalid_o, dbg_rdata_o, core_rvalid_o, core_rdata_o} !== {1'b1, w1, 1'b0, 32'h0}) begin
            bad++;
            $display("[TB] FAIL alt_dbg_data: got rvalid=%b rdata=%h core_rvalid=%b want 1 %h 0",
                     dbg_rvalid_o, dbg_rdata_o, core_rvalid_o, w1);
        end
        tick();
    endtask

    // Both sides hammer the port: every ninth cycle belongs to the core.
    task automatic test_conflict();
        logic ec;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        settle();
        tick();
        for (int k = 1; k <= 27; k++) begin
            drive(1'b1, 1'b0, rand_addr(), 32'h0, 1'b1, 1'b0, rand_addr(), 32'h0, 1'b0);
            settle();
            ec = (k % (LIMIT + 1) == 0);
            total++;
            if ({core_gnt_o, dbg_gnt_o, starve_o} !== {ec, !ec, ec}) begin
                bad++;
                $display("[TB] FAIL conflict_pattern cycle %0d: got core=%b dbg=%b starve=%b want %b %b %b",
                         k, core_gnt_o, dbg_gnt_o, starve_o, ec, !ec, ec);
            end
            total++;
            if (obs_o !== exp_o) begin
                bad++;
                $display("[TB] FAIL conflict_model cycle %0d: got %h want %h", k, obs_o, exp_o);
            end
            tick();
        end
    endtask

    // Halting freezes the earned credit; halting while force is pending
    // hands that cycle to debug instead.
    task automatic test_conflict_halted();
        logic h_seq[$];
        logic e_seq[$];
        for (int i = 0; i < 4; i++)  begin h_seq.push_back(1'b0); e_seq.push_back(1'b0); end
        for (int i = 0; i < 10; i++) begin h_seq.push_back(1'b1); e_seq.push_back(1'b0); end
        for (int i = 0; i < 4; i++)  begin h_seq.push_back(1'b0); e_seq.push_back(1'b0); end
        h_seq.push_back(1'b0); e_seq.push_back(1'b1);
        for (int i = 0; i < 8; i++)  begin h_seq.push_back(1'b0); e_seq.push_back(1'b0); end
        h_seq.push_back(1'b1); e_seq.push_back(1'b0);
        h_seq.push_back(1'b0); e_seq.push_back(1'b1);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        settle();
        tick();
        for (int k = 0; k < h_seq.size(); k++) begin
            drive(1'b1, 1'b0, rand_addr(), 32'h0, 1'b1, 1'b0, rand_addr(), 32'h0, h_seq[k]);
            settle();
            total++;
            if ({core_gnt_o, dbg_gnt_o, starve_o} !== {e_seq[k], !e_seq[k], e_seq[k]}) begin
                bad++;
                $display("[TB] FAIL halted_pattern step %0d halted=%b: got core=%b dbg=%b starve=%b want %b %b %b",
                         k, h_seq[k], core_gnt_o, dbg_gnt_o, starve_o, e_seq[k], !e_seq[k], e_seq[k]);
            end
            total++;
            if (obs_o !== exp_o) begin
                bad++;
                $display("[TB] FAIL halted_model step %0d: got %h want %h", k, obs_o, exp_o);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_read();
        logic ec;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        settle();
        tick();
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 1'b0, rand_addr(), 32'h0, 1'b1, 1'b0, rand_addr(), 32'h0, 1'b0);
            settle();
            tick();
        end
        rst_i = 1'b1;
        for (int k = 0; k < 2; k++) begin
            settle();
            total++;
            if (obs_o !== out_t'(0)) begin
                bad++;
                $display("[TB] FAIL mid_read_reset_outputs %0d: got %h want 0", k, obs_o);
            end
            tick();
        end
        rst_i = 1'b0;
        for (int k = 1; k <= LIMIT + 1; k++) begin
            drive(1'b1, 1'b0, rand_addr(), 32'h0, 1'b1, 1'b0, rand_addr(), 32'h0, 1'b0);
            settle();
            ec = (k == LIMIT + 1);
            total++;
            if ({core_gnt_o, dbg_gnt_o, starve_o} !== {ec, !ec, ec}) begin
                bad++;
                $display("[TB] FAIL mid_read_counter cycle %0d: got core=%b dbg=%b starve=%b want %b %b %b",
                         k, core_gnt_o, dbg_gnt_o, starve_o, ec, !ec, ec);
            end
            if (k == 1) begin
                total++;
                if ({dbg_rvalid_o, core_rvalid_o} !== 2'b00) begin
                    bad++;
                    $display("[TB] FAIL mid_read_dropped: got dbg_rvalid=%b core_rvalid=%b want 0 0",
                             dbg_rvalid_o, core_rvalid_o);
                end
            end
            tick();
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, rand_addr(), $urandom,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0, rand_addr(), $urandom,
                  $urandom_range(0, 7) == 0);
            settle();
            total++;
            if (obs_o !== exp_o) begin
                bad++;
                $display("[TB] FAIL random_model cycle %0d: got %h want %h", k, obs_o, exp_o);
            end
            total++;
            if (core_gnt_o && dbg_gnt_o) begin
                bad++;
                $display("[TB] FAIL random_one_grant cycle %0d: got core=1 dbg=1 want at most one", k);
            end
            tick();
        end
    endtask

    initial begin
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        @(negedge clk_i);
        test_reset();
        test_dbg_read();
        test_write();
        test_alternating();
        test_conflict();
        test_conflict_halted();
        test_reset_mid_read();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
